// File: rtl/sdram_burst_sequencer.sv
// Turns write/read FIFO trigger requests into SDRAM burst commands and tracks a
// circular frame buffer in SDRAM through write/read pointers and a stored-word count.
module sdram_burst_sequencer #(
   parameter int ADDR_W    = 22,
   parameter int WR_BURST  = 256,
   parameter int RD_BURST  = 243,
   parameter int BUF_BASE  = 0,
   parameter int BUF_WORDS = 62208
) (
   input  logic              wfifo_wclk,
   input  logic              s_rst_n,
   input  logic              wr_trig,
   input  logic              rd_trig,
   input  logic              ref_busy,
   output logic              cmd_valid,
   input  logic              cmd_ready,
   output logic              cmd_write,
   output logic [ADDR_W-1:0] cmd_addr,
   output logic [8:0]        cmd_len,
   input  logic              sdr_wdata_req,
   output logic [15:0]       sdr_wdata,
   output logic              wfifo_rd_en,
   input  logic [15:0]       wfifo_rd_data,
   input  logic              sdr_rdata_vld,
   input  logic [15:0]       sdr_rdata,
   output logic              rfifo_wr_en,
   output logic [15:0]       rfifo_wr_data,
   output logic              busy,
   output logic              burst_done,
   output logic              ovf_err
);

   localparam int SW = ADDR_W + 1;
   localparam logic [SW-1:0] WR_B  = SW'(WR_BURST);
   localparam logic [SW-1:0] RD_B  = SW'(RD_BURST);
   localparam logic [SW-1:0] BUF_W = SW'(BUF_WORDS);
   localparam logic [8:0]    WR_L  = 9'(WR_BURST);
   localparam logic [8:0]    RD_L  = 9'(RD_BURST);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_WCMD  = 3'd1;
   localparam logic [2:0] ST_WDATA = 3'd2;
   localparam logic [2:0] ST_RCMD  = 3'd3;
   localparam logic [2:0] ST_RDATA = 3'd4;

   logic [2:0]    r_state;
   logic [SW-1:0] r_wr_ptr;
   logic [SW-1:0] r_rd_ptr;
   logic [SW-1:0] r_stored;
   logic [8:0]    r_cnt;
   logic          r_ovf;
   logic          r_burst_done;
   logic          r_rfifo_wr_en;
   logic [15:0]   r_rfifo_wr_data;

   logic          w_wr_room;
   logic          w_rd_avail;
   logic [SW-1:0] w_wr_sum;
   logic [SW-1:0] w_rd_sum;
   logic [SW-1:0] w_wr_ptr_nxt;
   logic [SW-1:0] w_rd_ptr_nxt;
   logic          w_pop;
   logic          w_push;
   logic          w_wr_end;
   logic          w_rd_end;

   always_comb begin
      // one guard bit so stored+WR_BURST cannot wrap before the room compare
      w_wr_room    = ({1'b0, r_stored} + {1'b0, WR_B}) <= {1'b0, BUF_W};
      w_rd_avail   = r_stored >= RD_B;
      w_wr_sum     = r_wr_ptr + WR_B;
      w_rd_sum     = r_rd_ptr + RD_B;
      w_wr_ptr_nxt = (w_wr_sum >= BUF_W) ? '0 : w_wr_sum;
      w_rd_ptr_nxt = (w_rd_sum >= BUF_W) ? '0 : w_rd_sum;
      w_pop        = (r_state == ST_WDATA) && sdr_wdata_req && (r_cnt < WR_L);
      w_push       = (r_state == ST_RDATA) && sdr_rdata_vld && (r_cnt < RD_L);
      w_wr_end     = (r_state == ST_WDATA) && (r_cnt == WR_L);
      w_rd_end     = w_push && (r_cnt == RD_L - 9'd1);
   end

   always_comb begin
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = '0;
      cmd_len   = '0;
      if (r_state == ST_WCMD) begin
         cmd_valid = 1'b1;
         cmd_write = 1'b1;
         cmd_addr  = ADDR_W'(BUF_BASE) + ADDR_W'(r_wr_ptr);
         cmd_len   = WR_L;
      end else if (r_state == ST_RCMD) begin
         cmd_valid = 1'b1;
         cmd_addr  = ADDR_W'(BUF_BASE) + ADDR_W'(r_rd_ptr);
         cmd_len   = RD_L;
      end
   end

   assign wfifo_rd_en   = w_pop;
   assign sdr_wdata     = wfifo_rd_data;
   assign rfifo_wr_en   = r_rfifo_wr_en;
   assign rfifo_wr_data = r_rfifo_wr_data;
   assign busy          = (r_state != ST_IDLE);
   assign burst_done    = r_burst_done;
   assign ovf_err       = r_ovf;

   always_ff @(posedge wfifo_wclk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         r_state         <= ST_IDLE;
         r_wr_ptr        <= '0;
         r_rd_ptr        <= '0;
         r_stored        <= '0;
         r_cnt           <= '0;
         r_ovf           <= 1'b0;
         r_burst_done    <= 1'b0;
         r_rfifo_wr_en   <= 1'b0;
         r_rfifo_wr_data <= '0;
      end else begin
         r_burst_done  <= 1'b0;
         r_rfifo_wr_en <= w_push;
         if (w_push) r_rfifo_wr_data <= sdr_rdata;
         case (r_state)
            ST_IDLE: begin
               if (!ref_busy) begin
                  if (wr_trig && w_wr_room) begin
                     r_state <= ST_WCMD;
                  end else begin
                     if (wr_trig) r_ovf <= 1'b1;
                     if (rd_trig && w_rd_avail) r_state <= ST_RCMD;
                  end
               end
            end
            ST_WCMD: begin
               if (cmd_ready) begin
                  r_state <= ST_WDATA;
                  r_cnt   <= '0;
               end
            end
            ST_WDATA: begin
               if (w_wr_end) begin
                  r_state      <= ST_IDLE;
                  r_wr_ptr     <= w_wr_ptr_nxt;
                  r_stored     <= r_stored + WR_B;
                  r_burst_done <= 1'b1;
               end else if (w_pop) begin
                  r_cnt <= r_cnt + 9'd1;
               end
            end
            ST_RCMD: begin
               if (cmd_ready) begin
                  r_state <= ST_RDATA;
                  r_cnt   <= '0;
               end
            end
            ST_RDATA: begin
               if (w_push) begin
                  r_cnt <= r_cnt + 9'd1;
                  if (w_rd_end) begin
                     r_state      <= ST_IDLE;
                     r_rd_ptr     <= w_rd_ptr_nxt;
                     r_stored     <= r_stored - RD_B;
                     r_burst_done <= 1'b1;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sdram_burst_sequencer.sv
// Bench for sdram_burst_sequencer on a scaled buffer geometry (16/12-word bursts, 96 words)
// so that fill, wrap and overflow are reached within a short run.
module tb_sdram_burst_sequencer;

   localparam int AW   = 10;
   localparam int WRB  = 16;
   localparam int RDB  = 12;
   localparam int BASE = 64;
   localparam int BUFW = 96;

   logic          wfifo_wclk = 1'b0;
   logic          s_rst_n;
   logic          wr_trig, rd_trig, ref_busy, cmd_ready;
   logic          cmd_valid, cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [8:0]    cmd_len;
   logic          sdr_wdata_req;
   logic [15:0]   sdr_wdata;
   logic          wfifo_rd_en;
   logic [15:0]   wfifo_rd_data;
   logic          sdr_rdata_vld;
   logic [15:0]   sdr_rdata;
   logic          rfifo_wr_en;
   logic [15:0]   rfifo_wr_data;
   logic          busy, burst_done, ovf_err;

   always #5 wfifo_wclk = ~wfifo_wclk;

   sdram_burst_sequencer #(
      .ADDR_W(AW), .WR_BURST(WRB), .RD_BURST(RDB), .BUF_BASE(BASE), .BUF_WORDS(BUFW)
   ) dut (
      .wfifo_wclk(wfifo_wclk), .s_rst_n(s_rst_n), .wr_trig(wr_trig), .rd_trig(rd_trig),
      .ref_busy(ref_busy), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len), .sdr_wdata_req(sdr_wdata_req),
      .sdr_wdata(sdr_wdata), .wfifo_rd_en(wfifo_rd_en), .wfifo_rd_data(wfifo_rd_data),
      .sdr_rdata_vld(sdr_rdata_vld), .sdr_rdata(sdr_rdata), .rfifo_wr_en(rfifo_wr_en),
      .rfifo_wr_data(rfifo_wr_data), .busy(busy), .burst_done(burst_done), .ovf_err(ovf_err)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0d required=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: buffer bookkeeping plus a transaction phase (idle / command / data).
   int   m_phase;   // 0 idle, 1 command offered, 2 data transfer
   bit   m_is_wr;
   int   m_words, m_stored, m_wp, m_rp;
   bit   m_ovf, m_done, m_push;
   logic [15:0] m_pdata;

   always @(posedge wfifo_wclk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         m_phase = 0; m_is_wr = 0; m_words = 0; m_stored = 0; m_wp = 0; m_rp = 0;
         m_ovf = 0; m_done = 0; m_push = 0; m_pdata = '0;
      end else begin
         m_done = 0;
         m_push = (m_phase == 2) && !m_is_wr && sdr_rdata_vld;
         if (m_push) m_pdata = sdr_rdata;
         if (m_phase == 0) begin
            if (!ref_busy) begin
               if (wr_trig && (m_stored + WRB <= BUFW)) begin
                  m_phase = 1; m_is_wr = 1;
               end else begin
                  if (wr_trig) m_ovf = 1;
                  if (rd_trig && m_stored >= RDB) begin
                     m_phase = 1; m_is_wr = 0;
                  end
               end
            end
         end else if (m_phase == 1) begin
            if (cmd_ready) begin
               m_phase = 2; m_words = 0;
            end
         end else if (m_is_wr) begin
            if (m_words == WRB) begin
               m_stored += WRB; m_wp = (m_wp + WRB) % BUFW; m_done = 1; m_phase = 0;
            end else if (sdr_wdata_req) begin
               m_words++;
            end
         end else if (sdr_rdata_vld) begin
            m_words++;
            if (m_words == RDB) begin
               m_stored -= RDB; m_rp = (m_rp + RDB) % BUFW; m_done = 1; m_phase = 0;
            end
         end
      end
   end

   // Monitor counters and per-cycle comparison against the model.
   int   cmd_cnt = 0, pop_cnt = 0, push_cnt = 0, done_cnt = 0;
   int   last_addr, last_len;
   bit   last_write, prev_valid = 0, pop_pend = 0;

   always @(negedge wfifo_wclk) begin
      chk("busy", 32'(busy), 32'(m_phase != 0));
      chk("cmd_valid", 32'(cmd_valid), 32'(m_phase == 1));
      if (m_phase == 1) begin
         chk("cmd_write", 32'(cmd_write), 32'(m_is_wr));
         chk("cmd_addr", 32'(cmd_addr), 32'(BASE + (m_is_wr ? m_wp : m_rp)));
         chk("cmd_len", 32'(cmd_len), 32'(m_is_wr ? WRB : RDB));
      end
      chk("wfifo_rd_en", 32'(wfifo_rd_en),
          32'((m_phase == 2) && m_is_wr && sdr_wdata_req && (m_words < WRB)));
      chk("rfifo_wr_en", 32'(rfifo_wr_en), 32'(m_push));
      if (m_push) chk("rfifo_wr_data", 32'(rfifo_wr_data), 32'(m_pdata));
      chk("burst_done", 32'(burst_done), 32'(m_done));
      chk("ovf_err", 32'(ovf_err), 32'(m_ovf));
      chk("sdr_wdata", 32'(sdr_wdata), 32'(wfifo_rd_data));
      if (cmd_valid && !prev_valid) begin
         cmd_cnt++; last_addr = int'(cmd_addr); last_len = int'(cmd_len); last_write = cmd_write;
      end
      prev_valid = cmd_valid;
      if (wfifo_rd_en) pop_cnt++;
      if (rfifo_wr_en) push_cnt++;
      if (burst_done) done_cnt++;
      pop_pend = wfifo_rd_en;
   end

   // Write FIFO presents the next word one cycle after each pop; read data is random.
   always @(posedge wfifo_wclk) begin
      #1;
      if (pop_pend) wfifo_rd_data = wfifo_rd_data + 16'd1;
      sdr_rdata = 16'($urandom);
   end

   task automatic tick();
      @(posedge wfifo_wclk); #1;
   endtask

   task automatic do_reset();
      s_rst_n = 1'b0;
      wr_trig = 0; rd_trig = 0; ref_busy = 0; cmd_ready = 0; sdr_wdata_req = 0; sdr_rdata_vld = 0;
      repeat (3) @(posedge wfifo_wclk);
      #1 s_rst_n = 1'b1;
   endtask

   task automatic do_burst(input bit wr, input int exp_addr);
      int c0, d0, p0, q0;
      c0 = cmd_cnt; d0 = done_cnt; p0 = pop_cnt; q0 = push_cnt;
      tick();
      cmd_ready = 1; sdr_wdata_req = 1; sdr_rdata_vld = 1;
      if (wr) wr_trig = 1; else rd_trig = 1;
      for (int i = 0; i < 20 && cmd_cnt == c0; i++) tick();
      chk("cmd_seen", 32'(cmd_cnt - c0), 32'd1);
      if (wr) wr_trig = 0; else rd_trig = 0;
      chk("cmd_addr_lit", 32'(last_addr), 32'(exp_addr));
      chk("cmd_write_lit", 32'(last_write), 32'(wr));
      chk("cmd_len_lit", 32'(last_len), wr ? 32'd16 : 32'd12);
      for (int i = 0; i < 60 && done_cnt == d0; i++) tick();
      chk("done_seen", 32'(done_cnt - d0), 32'd1);
      if (wr) chk("pop_count", 32'(pop_cnt - p0), 32'd16);
      else    chk("push_count", 32'(push_cnt - q0), 32'd12);
   endtask

   initial begin
      int c0, d0, p0;
      wfifo_rd_data = 16'h1000;
      sdr_rdata = '0;
      do_reset();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
      chk("rst_rfifo_data", 32'(rfifo_wr_data), 32'd0);
      chk("rst_ovf", 32'(ovf_err), 32'd0);

      // read request with an empty buffer is ignored
      c0 = cmd_cnt;
      rd_trig = 1;
      repeat (10) tick();
      rd_trig = 0;
      chk("rd_empty_no_cmd", 32'(cmd_cnt - c0), 32'd0);

      do_burst(1, 64);
      chk("model_stored_w1", 32'(m_stored), 32'd16);

      // both triggers: write wins, then the held read is served
      wr_trig = 1; rd_trig = 1;
      do_burst(1, 80);
      do_burst(0, 64);
      chk("model_stored_r1", 32'(m_stored), 32'd20);

      // refresh blocks the start; command fields hold while not accepted
      tick();
      c0 = cmd_cnt; d0 = done_cnt; p0 = pop_cnt;
      ref_busy = 1; wr_trig = 1; cmd_ready = 0;
      repeat (8) tick();
      chk("refbusy_no_cmd", 32'(cmd_cnt - c0), 32'd0);
      chk("refbusy_idle", 32'(busy), 32'd0);
      ref_busy = 0;
      for (int i = 0; i < 10 && cmd_cnt == c0; i++) tick();
      wr_trig = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge wfifo_wclk);
         chk("hold_valid", 32'(cmd_valid), 32'd1);
         chk("hold_addr", 32'(cmd_addr), 32'd96);
         chk("hold_len", 32'(cmd_len), 32'd16);
      end
      tick();
      cmd_ready = 1;
      for (int i = 0; i < 60 && done_cnt == d0; i++) tick();
      chk("hold_done", 32'(done_cnt - d0), 32'd1);
      chk("hold_pops", 32'(pop_cnt - p0), 32'd16);

      // fill to wrap, free space, write at the wrapped pointer
      do_burst(1, 112);
      do_burst(1, 128);
      do_burst(1, 144);
      chk("model_wp_wrap", 32'(m_wp), 32'd0);
      do_burst(0, 76);
      do_burst(1, 64);
      chk("model_stored_full", 32'(m_stored), 32'd88);

      // write refused (overflow) falls through to the read
      wr_trig = 1;
      do_burst(0, 88);
      chk("ovf_lit", 32'(ovf_err), 32'd1);
      do_burst(1, 80);
      c0 = cmd_cnt;
      wr_trig = 1;
      repeat (6) tick();
      wr_trig = 0;
      chk("full_no_cmd", 32'(cmd_cnt - c0), 32'd0);

      // asynchronous reset in the middle of a write burst
      do_reset();
      p0 = pop_cnt;
      wr_trig = 1; cmd_ready = 1; sdr_wdata_req = 1;
      for (int i = 0; i < 40 && (pop_cnt - p0) < 10; i++) tick();
      chk("mid_pops", 32'(pop_cnt - p0), 32'd10);
      d0 = done_cnt;
      #2 s_rst_n = 1'b0;
      #1;
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_rd_en", 32'(wfifo_rd_en), 32'd0);
      chk("arst_cmd_valid", 32'(cmd_valid), 32'd0);
      chk("arst_done", 32'(burst_done), 32'd0);
      wr_trig = 0;
      repeat (3) @(posedge wfifo_wclk);
      #1 s_rst_n = 1'b1;
      chk("arst_no_done", 32'(done_cnt - d0), 32'd0);
      do_burst(1, 64);
      do_burst(0, 64);
      chk("model_stored_post", 32'(m_stored), 32'd4);

      // randomized traffic, checked cycle by cycle against the model
      for (int i = 0; i < 3000; i++) begin
         tick();
         wr_trig       = ($urandom_range(0, 9) < 3);
         rd_trig       = ($urandom_range(0, 9) < 4);
         ref_busy      = ($urandom_range(0, 9) < 2);
         cmd_ready     = ($urandom_range(0, 9) < 6);
         sdr_wdata_req = ($urandom_range(0, 9) < 8);
         sdr_rdata_vld = ($urandom_range(0, 9) < 7);
      end
      wr_trig = 0; rd_trig = 0;
      repeat (5) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
